// File: rtl/lmu_acc_ctrl.sv
// LMU front stage: measurement-window sign accumulators, Pauli-frame byproduct register
// and feedback bookkeeping, presented to the interpret stage via a ready/take handshake.
`ifndef NUM_LQ
`define NUM_LQ 4
`endif
`ifndef MEASSIGN_PLUS
`define MEASSIGN_PLUS 1'b0
`endif
`ifndef MEASSIGN_MINUS
`define MEASSIGN_MINUS 1'b1
`endif

// state  | meaning
// IDLE   | no open window; accumulators hold the last result
// ACCUM  | window open; valid beats are XOR-accumulated and counted
// READY  | window closed; frozen state offered to the interpret stage
module lmu_acc_ctrl #(
    parameter int NUM_LQ = `NUM_LQ,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  meas_start,
    input  logic                  inst_meas_sign,
    input  logic                  lqsign_valid,
    input  logic [NUM_LQ-1:0]     lqsignX_in,
    input  logic [NUM_LQ-1:0]     lqsignZ_in,
    input  logic                  lqsign_last,
    input  logic                  interp_take,
    input  logic [2*NUM_LQ-1:0]   next_byproduct,
    input  logic                  bp_upd_en,
    input  logic                  a_valid,
    output logic [NUM_LQ-1:0]     lqsignX_acc_reg,
    output logic [NUM_LQ-1:0]     lqsignZ_acc_reg,
    output logic [2*NUM_LQ-1:0]   byproduct_reg,
    output logic                  a_taken_reg,
    output logic                  a_sign_reg,
    output logic                  acc_ready,
    output logic [CNT_W-1:0]      acc_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q;
    state_t state_d;
    logic   beat_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // meas_start overrides every other transition, including take in READY
    always_comb begin
        state_d = state_q;
        if (meas_start) begin
            state_d = S_ACCUM;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_ACCUM: if (lqsign_valid && lqsign_last) state_d = S_READY;
                S_READY: if (interp_take) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_ready = (state_q == S_READY);
        beat_en   = (state_q == S_ACCUM) && lqsign_valid && !meas_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lqsignX_acc_reg <= '0;
            lqsignZ_acc_reg <= '0;
            acc_cnt         <= '0;
            byproduct_reg   <= '0;
            a_taken_reg     <= 1'b0;
            a_sign_reg      <= `MEASSIGN_PLUS;
        end else begin
            // the byproduct register belongs to the interpret stage's loop, not the window
            if (bp_upd_en) begin
                byproduct_reg <= next_byproduct;
            end
            if (meas_start) begin
                lqsignX_acc_reg <= '0;
                lqsignZ_acc_reg <= '0;
                acc_cnt         <= '0;
                a_taken_reg     <= 1'b0;
                a_sign_reg      <= inst_meas_sign;
            end else begin
                if (beat_en) begin
                    lqsignX_acc_reg <= lqsignX_acc_reg ^ lqsignX_in;
                    lqsignZ_acc_reg <= lqsignZ_acc_reg ^ lqsignZ_in;
                    if (acc_cnt != CNT_MAX) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                end
                if (a_valid && !a_taken_reg) begin
                    a_taken_reg <= 1'b1;
                end
            end
        end
    end

endmodule
